apb_slave_mem: RTL

//  APB completer attached to the slave side of the shared APB interface (one PSEL bit per completer).
//  - Decodes its own PSEL bit and serves reads/writes from an internal word memory.
//  - Inserts a runtime-programmable number of wait states.
//  - Is the responder counterpart used by the VIP master and by the DUT-side integration benches.

---
 rtl/apb_slv_pkg.sv | 28 ++
 rtl/apb_slv_ram.sv | 26 ++
 rtl/apb_slave_mem.sv | 122 ++++++++++++
 3 files changed

// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB memory completer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package apb_slv_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_slv_state_e;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_MEM_DEPTH  = 256;

   // Byte-lane bits below the word index, and word-index width.
   function automatic int bl_of(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   function automatic int iw_of(input int mem_depth);
      return $clog2(mem_depth);
   endfunction

   localparam int BL = $clog2(DEF_DATA_WIDTH / 8);
   localparam int IW = $clog2(DEF_MEM_DEPTH);

   localparam logic [7:0] OOR_MAX = 8'hFF;

endpackage

// File: rtl/apb_slv_ram.sv
// Word memory behind the APB completer: synchronous write, registered read, no reset.
// Latency: read data appears one clock after re; write commits on the clock edge.
// Backpressure: none, accepts a read and a write every cycle.
// Ports: clk; we/waddr/wdata write port; re/raddr read port; rdata registered read data.
module apb_slv_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 256,
   parameter int AW         = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer serving reads/writes from an internal word memory with programmable wait states.
// Latency: setup + (1 + wait_cfg) access cycles per transfer; back-to-back setups accepted.
// Backpressure: PREADY held low for wait_cfg access cycles; PSEL drop aborts the transfer.
// Ports: PCLK/PRESET; APB completer signals PADDR, PWRITE, PSEL, PENABLE, PWDATA, PREADY, PRDATA;
//        wait_cfg (wait states, sampled in setup); oor_cnt (saturating out-of-range access count).
`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif
`ifndef D_SLV_COUNT
`define D_SLV_COUNT 4
`endif

module apb_slave_mem
   import apb_slv_pkg::*;
#(
   parameter int ADDR_WIDTH = `D_ADDR_WIDTH,
   parameter int DATA_WIDTH = `D_DATA_WIDTH,
   parameter int SLV_COUNT  = `D_SLV_COUNT,
   parameter int SLV_IDX    = 0,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic                  PWRITE,
   input  logic [SLV_COUNT-1:0]  PSEL,
   input  logic                  PENABLE,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   output logic                  PREADY,
   output logic [DATA_WIDTH-1:0] PRDATA,
   input  logic [3:0]            wait_cfg,
   output logic [7:0]            oor_cnt
);

   localparam int ABL = bl_of(DATA_WIDTH);
   localparam int AIW = iw_of(MEM_DEPTH);
   localparam int AHI = ABL + AIW;

   apb_slv_state_e        state;
   logic [AIW-1:0]        idx_q;
   logic                  write_q;
   logic                  oor_q;
   logic [3:0]            cnt;
   logic [DATA_WIDTH-1:0] ram_rdata;

   logic                  sel;
   logic [AIW-1:0]        idx;
   logic                  oor;
   logic                  setup;
   logic                  complete;
   logic                  ram_we;
   logic                  unused_bits;

   assign sel      = PSEL[SLV_IDX];
   assign idx      = PADDR[ABL +: AIW];
   assign oor      = |PADDR[ADDR_WIDTH-1:AHI];
   assign setup    = (state == IDLE) && sel && !PENABLE;
   assign complete = (state == ACCESS) && sel && PENABLE && (cnt == 4'd0);
   assign ram_we   = complete && write_q && !oor_q;

   // Byte-lane address bits and foreign PSEL bits are deliberately ignored.
   assign unused_bits = ^{PADDR, PSEL};

   // Read data is fetched during setup so it is ready on the first access cycle;
   // a write commits on its completion edge, ahead of any following setup.
   apb_slv_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_DEPTH  (MEM_DEPTH),
      .AW         (AIW)
   ) u_ram (
      .clk   (PCLK),
      .we    (ram_we),
      .waddr (idx_q),
      .wdata (PWDATA),
      .re    (setup),
      .raddr (idx),
      .rdata (ram_rdata)
   );

   // Both outputs decode registered state only; no input reaches them combinationally.
   assign PREADY = (state == ACCESS) && (cnt == 4'd0);
   assign PRDATA = ((state == ACCESS) && !write_q && !oor_q) ? ram_rdata : '0;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state   <= IDLE;
         idx_q   <= '0;
         write_q <= 1'b0;
         oor_q   <= 1'b0;
         cnt     <= 4'd0;
         oor_cnt <= 8'd0;
      end else begin
         unique case (state)
            IDLE: begin
               // sel & PENABLE with no setup phase is a protocol error and is ignored.
               if (setup) begin
                  idx_q   <= idx;
                  write_q <= PWRITE;
                  oor_q   <= oor;
                  cnt     <= wait_cfg;
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               if (!sel) begin
                  state <= IDLE;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else if (PENABLE) begin
                  if (oor_q && (oor_cnt != OOR_MAX)) oor_cnt <= oor_cnt + 8'd1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
